// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Optional checksum stage is enabled by IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned COUNT_BYTES = 4;
  localparam int unsigned WORD_BYTES  = 4;
  localparam int unsigned BCNT_W      = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_DATA  = 3'd1,
    ST_RUN   = 3'd2,
    ST_ERROR = 3'd3
`ifdef IMEM_LOADER_CHECKSUM_EN
    , ST_CHECK = 3'd4
`endif
  } state_e;

  // Byte address of payload word idx relative to base; wraps modulo 2^32.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [WORD_W-1:0] idx);
    return base + WORD_W'(idx * WORD_BYTES);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler; word_valid_c/word_c present the
// completed word combinationally in the cycle its last byte is accepted.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              word_valid_c,
  output logic [WORD_W-1:0] word_c
);

  logic [WORD_W-1:0] shift_q;
  logic [BCNT_W-1:0] byte_cnt_q;

  // Newest byte enters at the top, so after four bytes the first sits in [7:0].
  assign word_c       = {byte_data, shift_q[WORD_W-1:BYTE_W]};
  assign word_valid_c = byte_valid && (byte_cnt_q == BCNT_W'(WORD_BYTES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q    <= '0;
      byte_cnt_q <= '0;
    end else if (byte_valid) begin
      shift_q    <= word_c;
      byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into instruction memory and
// holds the CPU in reset until loaded. Macro IMEM_LOADER_CHECKSUM_EN adds an XOR checksum byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned       IMEM_WORDS = 1024,
  parameter logic [WORD_W-1:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [WORD_W-1:0] imem_waddr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e ST_AFTER_DATA = ST_CHECK;
`else
  localparam state_e ST_AFTER_DATA = ST_RUN;
`endif

  state_e            state_q, state_d;
  logic [WORD_W-1:0] count_q, count_d;
  logic [WORD_W-1:0] widx_q, widx_d;
  logic              imem_we_d;
  logic [WORD_W-1:0] imem_waddr_d, imem_wdata_d;
  logic              rx_ready_d, cpu_reset_d, load_done_d, error_d;

  logic              accept;
  logic              asm_valid;
  logic              word_valid_c;
  logic [WORD_W-1:0] word_c;

  assign accept    = rx_valid && rx_ready;
  assign asm_valid = accept && (state_q == ST_COUNT || state_q == ST_DATA);

  // One assembler serves both the count field and the payload words.
  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .byte_valid   (asm_valid),
    .byte_data    (rx_data),
    .word_valid_c (word_valid_c),
    .word_c       (word_c)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] csum_q, csum_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    widx_d       = widx_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr;
    imem_wdata_d = imem_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_COUNT: begin
        if (word_valid_c) begin
          count_d = word_c;
          widx_d  = '0;
          if (word_c > WORD_W'(IMEM_WORDS)) state_d = ST_ERROR;
          else if (word_c == '0)            state_d = ST_AFTER_DATA;
          else                              state_d = ST_DATA;
        end
      end
      ST_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) csum_d = csum_q ^ rx_data;
`endif
        if (word_valid_c) begin
          imem_we_d    = 1'b1;
          imem_waddr_d = word_addr(BASE_ADDR, widx_q);
          imem_wdata_d = word_c;
          widx_d       = widx_q + WORD_W'(1);
          if (widx_q == count_q - WORD_W'(1)) state_d = ST_AFTER_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (accept) state_d = (rx_data == csum_q) ? ST_RUN : ST_ERROR;
      end
`endif
      ST_RUN:   state_d = ST_RUN;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    rx_ready_d  = (state_d == ST_COUNT) || (state_d == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                  || (state_d == ST_CHECK)
`endif
                  ;
    error_d     = (state_d == ST_ERROR);
    // CPU release follows the state by one cycle so the final write strobe
    // is still under cpu_reset when it commits.
    cpu_reset_d = (state_q != ST_RUN);
    load_done_d = (state_q == ST_RUN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_COUNT;
      count_q    <= '0;
      widx_q     <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      rx_ready   <= 1'b1;
      cpu_reset  <= 1'b1;
      load_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      widx_q     <= widx_d;
      imem_we    <= imem_we_d;
      imem_waddr <= imem_waddr_d;
      imem_wdata <= imem_wdata_d;
      rx_ready   <= rx_ready_d;
      cpu_reset  <= cpu_reset_d;
      load_done  <= load_done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random images against a
// stream-level reference model (follows IMEM_LOADER_CHECKSUM_EN).
module tb_imem_loader;

  localparam int unsigned IW = 16;
  localparam logic [31:0] BA = 32'h0000_0000;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk, reset, rx_valid, rx_ready;
  logic [7:0]  rx_data;
  logic        imem_we, cpu_reset, load_done, error;
  logic [31:0] imem_waddr, imem_wdata;

  int checks = 0;
  int errors = 0;
  logic [63:0] wr_q[$];
  logic [31:0] img_words[$];

  imem_loader #(.IMEM_WORDS(IW), .BASE_ADDR(BA)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .error      (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor, sampled away from the active edge.
  always @(negedge clk) if (imem_we) wr_q.push_back({imem_waddr, imem_wdata});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode);
    int w = 0;
    int gap;
    while (rx_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk("rx_ready_wait", 64'(rx_ready), 64'd1);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    gap = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(0, 2));
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_we",        64'(imem_we),    64'd0);
    chk("rst_waddr",     64'(imem_waddr), 64'd0);
    chk("rst_wdata",     64'(imem_wdata), 64'd0);
    chk("rst_cpu_reset", 64'(cpu_reset),  64'd1);
    chk("rst_load_done", 64'(load_done),  64'd0);
    chk("rst_error",     64'(error),      64'd0);
    rx_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
  endtask

  // Streams count n plus img_words (and checksum ^ csum_delta), then checks
  // writes and final status against the stream-level rules.
  task automatic run_image(input string tag, input logic [31:0] n,
                           input logic [7:0] csum_delta, input int mode);
    logic [7:0]  x = 8'h00;
    logic [63:0] exp_q[$];
    logic [31:0] nw;
    bit          exp_err;
    int          nmin;
    wr_q.delete();
    for (int b = 0; b < 4; b++) send_byte(n[8*b +: 8], mode);
    if (n > IW) begin
      exp_err = 1'b1;
    end else begin
      for (int k = 0; k < int'(n); k++) begin
        nw = img_words[k];
        for (int b = 0; b < 4; b++) begin
          x ^= nw[8*b +: 8];
          send_byte(nw[8*b +: 8], mode);
        end
        exp_q.push_back({BA + 32'(4 * k), nw});
      end
      if (CSUM_EN) send_byte(x ^ csum_delta, mode);
      exp_err = CSUM_EN && (csum_delta != 8'h00);
    end
    repeat (3) @(negedge clk);
    // Bytes offered after the load ends must be ignored.
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_nwrites"}, 64'(wr_q.size()), 64'(exp_q.size()));
    nmin = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) chk({tag, "_write"}, wr_q[i], exp_q[i]);
    chk({tag, "_error"},     64'(error),     64'(exp_err));
    chk({tag, "_load_done"}, 64'(load_done), 64'(!exp_err));
    chk({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(exp_err));
    chk({tag, "_rx_ready"},  64'(rx_ready),  64'd0);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    do_reset();

    // Reference two-word image, back-to-back then with rx_valid toggling.
    img_words = '{32'h0000_0013, 32'h1234_5678};
    run_image("basic", 32'd2, 8'h00, 0);
    chk("basic_w0", wr_q.size() > 0 ? wr_q[0] : 64'hx, {32'h0, 32'h13});
    do_reset();
    run_image("toggle", 32'd2, 8'h00, 1);
    chk("toggle_w1", wr_q.size() > 1 ? wr_q[1] : 64'hx, {32'h4, 32'h1234_5678});
    do_reset();

    // Corrupted checksum (rejected only when the checksum stage exists).
    run_image("badsum", 32'd2, 8'h5A, 0);
    do_reset();

    // Oversize count, empty image, full-capacity image.
    img_words.delete();
    run_image("oversize", 32'(IW + 1), 8'h00, 0);
    do_reset();
    run_image("empty", 32'd0, 8'h00, 0);
    do_reset();
    for (int k = 0; k < int'(IW); k++) img_words.push_back($urandom);
    run_image("full", 32'(IW), 8'h00, 2);
    do_reset();

    // Reset after five payload bytes abandons the image.
    img_words = '{32'h0000_0013, 32'h1234_5678};
    for (int b = 0; b < 4; b++) send_byte(8'(b == 0 ? 2 : 0), 0);
    for (int b = 0; b < 5; b++) send_byte(8'($urandom), 0);
    reset = 1'b1;
    wr_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_nowrite", 64'(wr_q.size()), 64'd0);
    run_image("after_rst", 32'd2, 8'h00, 0);
    do_reset();

    // Random images with random pacing and occasional bad checksums.
    for (int r = 0; r < 4; r++) begin
      int unsigned n = $urandom_range(1, IW);
      img_words.delete();
      for (int k = 0; k < int'(n); k++) img_words.push_back($urandom);
      run_image("rand", 32'(n), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), 2);
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
